// File: rtl/lzrw_pkg.sv
// Shared types and sizing for the LZRW1 compressor datapath.
// Holds table geometry, the table entry layout and the lookup controller states.
package lzrw_pkg;

  localparam int IDX_W = 12;
  localparam int PTR_W = 16;
  localparam int KEY_W = 24;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] ptr;
  } tbl_entry_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_READ,
    ST_UPDATE,
    ST_RESP
  } hctrl_state_t;

endpackage

// File: rtl/hash_table_ctrl.sv
// LZRW1 hash-table sequencer: hash the key, read the old pointer, overwrite it with
// the current position and hand the old entry to the match stage. Clears the table after reset/start.
module hash_table_ctrl
  import lzrw_pkg::*;
#(
  parameter int IDX_W = lzrw_pkg::IDX_W,
  parameter int PTR_W = lzrw_pkg::PTR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [lzrw_pkg::KEY_W-1:0] req_key,
  input  logic [PTR_W-1:0]           req_pos,
  output logic [lzrw_pkg::KEY_W-1:0] hash_key,
  input  logic [IDX_W-1:0]           hash_idx,
  output logic [IDX_W-1:0]           tbl_addr,
  output logic                       tbl_we,
  output logic [PTR_W:0]             tbl_wdata,
  input  logic [PTR_W:0]             tbl_rdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_hit,
  output logic [PTR_W-1:0]           rsp_ptr
);

  hctrl_state_t                state, state_nxt;
  logic [IDX_W-1:0]            clr_cnt;
  logic [IDX_W-1:0]            idx_r;
  logic [lzrw_pkg::KEY_W-1:0]  key_r;
  logic [PTR_W-1:0]            pos_r;
  logic                        rsp_hit_r;
  logic [PTR_W-1:0]            rsp_ptr_r;
  logic                        clr_last;
  logic                        req_fire;

  assign clr_last = &clr_cnt;
  assign req_fire = (state == ST_IDLE) && !start && req_valid;

  assign hash_key = key_r;
  assign rsp_hit  = rsp_hit_r;
  assign rsp_ptr  = rsp_ptr_r;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    req_ready = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = idx_r;
    tbl_wdata = '0;
    rsp_valid = 1'b0;

    case (state)
      ST_CLEAR: begin
        busy     = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = clr_cnt;
        if (clr_last) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        req_ready = !start;
        if (start)          state_nxt = ST_CLEAR;
        else if (req_valid) state_nxt = ST_READ;
      end
      ST_READ: begin
        // Hash unit is combinational off key_r, so the index is usable immediately.
        tbl_addr  = hash_idx;
        state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        tbl_we    = 1'b1;
        tbl_addr  = idx_r;
        tbl_wdata = {1'b1, pos_r};
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase

    // While reset is held, nothing may touch the table or handshake.
    if (reset) begin
      busy      = 1'b1;
      req_ready = 1'b0;
      tbl_we    = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR)
        clr_cnt <= clr_cnt + 1'b1;
      else if (state == ST_IDLE && start)
        clr_cnt <= '0;
    end
  end

  // Lookup stage registers: key/pos at accept, index at READ, old entry at UPDATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_r     <= '0;
      pos_r     <= '0;
      idx_r     <= '0;
      rsp_hit_r <= 1'b0;
      rsp_ptr_r <= '0;
    end else begin
      if (req_fire) begin
        key_r <= req_key;
        pos_r <= req_pos;
      end
      if (state == ST_READ)
        idx_r <= hash_idx;
      if (state == ST_UPDATE) begin
        rsp_hit_r <= tbl_rdata[PTR_W];
        rsp_ptr_r <= tbl_rdata[PTR_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hash_table_ctrl.sv
// Bench for hash_table_ctrl: LZRW1 hash unit and table RAM are modelled here, and a
// dictionary-level reference predicts every output cycle by cycle.
module tb_hash_table_ctrl;

  localparam int IDX_W = 12;
  localparam int PTR_W = 16;
  localparam int DEPTH = 1 << IDX_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [23:0]       req_key = '0;
  logic [PTR_W-1:0]  req_pos = '0;
  logic [23:0]       hash_key;
  logic [IDX_W-1:0]  hash_idx;
  logic [IDX_W-1:0]  tbl_addr;
  logic              tbl_we;
  logic [PTR_W:0]    tbl_wdata;
  logic [PTR_W:0]    tbl_rdata;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic              rsp_hit;
  logic [PTR_W-1:0]  rsp_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hash_table_ctrl #(.IDX_W(IDX_W), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_pos(req_pos),
    .hash_key(hash_key), .hash_idx(hash_idx),
    .tbl_addr(tbl_addr), .tbl_we(tbl_we), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_ptr(rsp_ptr)
  );

  // LZRW1 hash: ((40543 * (((b0<<4)^b1)<<4 ^ b2)) >> 4) & 0xFFF
  function automatic logic [IDX_W-1:0] hash_fn(input logic [23:0] k);
    int unsigned t;
    t = (((32'(k[23:16]) << 4) ^ 32'(k[15:8])) << 4) ^ 32'(k[7:0]);
    t = (t * 32'd40543) >> 4;
    return t[IDX_W-1:0];
  endfunction

  assign hash_idx = hash_fn(hash_key);

  logic [PTR_W:0] mem [DEPTH];
  always @(posedge clk) begin
    if (tbl_we) mem[tbl_addr] <= tbl_wdata;
    tbl_rdata <= mem[tbl_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: dictionary of hash index -> {valid,ptr}, plus clear/lookup progress counters.
  logic [PTR_W:0]   dict [int];
  int               m_clr_rem = 0;
  int               m_age = 0;
  logic [23:0]      m_key = '0;
  logic [PTR_W-1:0] m_pos = '0;
  logic             m_hit = 1'b0;
  logic [PTR_W-1:0] m_ptr = '0;

  task automatic check_outputs();
    if (reset) begin
      chk("rst_busy", 32'(busy), 1);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_tbl_we", 32'(tbl_we), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
    end else begin
      chk("hash_key", 32'(hash_key), 32'(m_key));
      if (m_clr_rem > 0) begin
        chk("clr_busy", 32'(busy), 1);
        chk("clr_we", 32'(tbl_we), 1);
        chk("clr_addr", 32'(tbl_addr), 32'(DEPTH - m_clr_rem));
        chk("clr_wdata", 32'(tbl_wdata), 0);
        chk("clr_req_ready", 32'(req_ready), 0);
        chk("clr_rsp_valid", 32'(rsp_valid), 0);
      end else if (m_age == 0) begin
        chk("idle_busy", 32'(busy), 0);
        chk("idle_req_ready", 32'(req_ready), 32'(!start));
        chk("idle_we", 32'(tbl_we), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
      end else if (m_age == 1) begin
        chk("rd_busy", 32'(busy), 0);
        chk("rd_req_ready", 32'(req_ready), 0);
        chk("rd_we", 32'(tbl_we), 0);
        chk("rd_addr", 32'(tbl_addr), 32'(hash_fn(m_key)));
        chk("rd_rsp_valid", 32'(rsp_valid), 0);
      end else if (m_age == 2) begin
        chk("upd_req_ready", 32'(req_ready), 0);
        chk("upd_we", 32'(tbl_we), 1);
        chk("upd_addr", 32'(tbl_addr), 32'(hash_fn(m_key)));
        chk("upd_wdata", 32'(tbl_wdata), 32'({1'b1, m_pos}));
        chk("upd_rsp_valid", 32'(rsp_valid), 0);
      end else begin
        chk("rsp_busy", 32'(busy), 0);
        chk("rsp_req_ready", 32'(req_ready), 0);
        chk("rsp_we", 32'(tbl_we), 0);
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_hit", 32'(rsp_hit), 32'(m_hit));
        chk("rsp_ptr", 32'(rsp_ptr), 32'(m_ptr));
      end
    end
  endtask

  task automatic update_model();
    int idx;
    if (reset) begin
      m_clr_rem = DEPTH;
      m_age = 0;
      m_key = '0;
      m_pos = '0;
      dict.delete();
    end else if (m_clr_rem > 0) begin
      m_clr_rem--;
    end else if (m_age == 0) begin
      if (start) begin
        m_clr_rem = DEPTH;
        dict.delete();
      end else if (req_valid) begin
        idx   = int'(hash_fn(req_key));
        m_key = req_key;
        m_pos = req_pos;
        if (dict.exists(idx)) {m_hit, m_ptr} = dict[idx];
        else                  {m_hit, m_ptr} = '0;
        dict[idx] = {1'b1, req_pos};
        m_age = 1;
      end
    end else if (m_age >= 3 && rsp_ready) begin
      m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      update_model();
    end
  end

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!req_ready && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!req_ready) chk("wait_ready_timeout", 32'(req_ready), 1);
  endtask

  task automatic lookup(input logic [23:0] key, input logic [PTR_W-1:0] pos, input int hold,
                        input logic exp_hit, input logic [PTR_W-1:0] exp_ptr, input bit lit);
    int c;
    wait_ready(c);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_key = key; req_pos = pos;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("lat3_rsp_valid", 32'(rsp_valid), 1);
    if (lit) begin
      chk("lit_rsp_hit", 32'(rsp_hit), 32'(exp_hit));
      chk("lit_rsp_ptr", 32'(rsp_ptr), 32'(exp_ptr));
    end
    repeat (hold) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", 32'(req_ready), 1);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(c);
    chk("reset_clear_len", 32'(c), 4096);

    lookup(24'h616263, 16'd5, 0, 1'b0, 16'd0, 1'b1);
    lookup(24'h616263, 16'd9, 10, 1'b1, 16'd5, 1'b1);
    lookup(24'h414243, 16'd12, 2, 1'b0, 16'd0, 1'b1);
    lookup(24'h616263, 16'd14, 0, 1'b1, 16'd9, 1'b1);

    // start and req_valid together: start wins and the table is wiped
    wait_ready(c);
    start = 1'b1; req_valid = 1'b1; req_key = 24'h616263; req_pos = 16'd77;
    @(posedge clk); #1;
    start = 1'b0; req_valid = 1'b0;
    wait_ready(c);
    chk("start_clear_len", 32'(c), 4096);
    lookup(24'h616263, 16'd20, 0, 1'b0, 16'd0, 1'b1);

    // reset pulsed during UPDATE
    wait_ready(c);
    req_valid = 1'b1; req_key = 24'h616263; req_pos = 16'd25;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_reset_addr", 32'(tbl_addr), 0);
    wait_ready(c);
    chk("reset_mid_clear_len", 32'(c), 4096);
    lookup(24'h616263, 16'd30, 0, 1'b0, 16'd0, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) req_key = 24'($urandom);
      else req_key = {16'h6162, 4'h6, 4'($urandom_range(0, 7))};
      req_pos   = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 1499) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; start = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hash_table_ctrl.md
# hash_table_ctrl

Sequencer for the LZRW1 hash-table lookup/update step. For each input position it accepts the next 3-byte key and position, routes the key through the external combinational hash unit, and reads the table-of-pointers RAM at the hashed index. It then overwrites that entry with the current position and returns the old entry to the match stage. It also clears the whole table after reset and on `start`, so every compression block begins from an empty dictionary.

## Interface
Parameters:
- `IDX_W`, 12: hash index width; table depth `DEPTH = 2**IDX_W`.
- `PTR_W`, 16: position pointer width.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a new block and clear the table; sampled only in IDLE.
- `busy`, out, 1: high during CLEAR.
- `req_valid`, in, 1: lookup request valid.
- `req_ready`, out, 1: controller can accept a request.
- `req_key`, in, 24: bytes {b0,b1,b2} at the current position.
- `req_pos`, in, PTR_W: current input position.
- `hash_key`, out, 24: to the hash unit; registered copy of the accepted key.
- `hash_idx`, in, IDX_W: from the hash unit; combinational function of `hash_key`.
- `tbl_addr`, out, IDX_W: table RAM address.
- `tbl_we`, out, 1: table RAM write enable.
- `tbl_wdata`, out, PTR_W+1: entry written as {valid, ptr}.
- `tbl_rdata`, in, PTR_W+1: RAM read data, available 1 cycle after the address.
- `rsp_valid`, out, 1: response valid.
- `rsp_ready`, in, 1: match stage accepts the response.
- `rsp_hit`, out, 1: the entry read was valid.
- `rsp_ptr`, out, PTR_W: previous position stored at the index.

## Operation
- States: CLEAR, IDLE, READ, UPDATE, RESP.
- **CLEAR**
  - `tbl_we`=1, `tbl_addr`=`clr_cnt`, `tbl_wdata`=0, `busy`=1.
  - `clr_cnt` increments each cycle.
  - At `clr_cnt`==DEPTH-1, go to IDLE and reset `clr_cnt` to 0.
- **IDLE**
  - `req_ready` = !`start`. `start` has priority over `req_valid`.
  - `start`=1: go to CLEAR.
  - `req_valid && req_ready`: latch `req_key` into the key register (drives `hash_key`), latch `req_pos` into `pos_r`, go to READ.
- **READ**
  - `tbl_addr`=`hash_idx`, `tbl_we`=0.
  - Latch `hash_idx` into `idx_r`. Go to UPDATE.
- **UPDATE**
  - Capture `tbl_rdata` into the response registers.
  - Write at `idx_r`: `tbl_we`=1, `tbl_wdata`={1'b1, `pos_r`}.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_hit`/`rsp_ptr` stay stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- `req_ready`=0 in every state except IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Collision: the entry is always overwritten (LZRW1 single-slot policy). The old value is returned regardless of whether its key matched.
- `hash_key` holds its last value outside lookups. Because the hash unit is combinational, `hash_idx` is valid from the first READ cycle.

## Timing
- Reset values:
  - State=CLEAR, `clr_cnt`=0, key register=0, `pos_r`=0, `idx_r`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_hit`=0, `rsp_ptr`=0.
  - `busy`=1.
  - `tbl_we`=0 while `reset` is high.
- Clear sequence:
  - The first cycle with `reset` low writes address 0.
  - Cycle DEPTH-1 writes address DEPTH-1.
  - Cycle DEPTH: IDLE, `busy`=0, `req_ready`=1.
- `start` accepted in IDLE at cycle T: cycles T+1 … T+DEPTH are CLEAR; IDLE resumes at T+DEPTH+1.
- Lookup handshake at cycle N:
  - N+1: READ.
  - N+2: UPDATE write.
  - N+3: `rsp_valid`=1.
- Response accepted at N+3: IDLE at N+4. Maximum throughput is one lookup per 4 cycles.
- Back-pressure: `rsp_ready` low holds RESP indefinitely, with no table access.
- Reset asserted mid-lookup or mid-clear: the next cycle is CLEAR with `clr_cnt`=0. Any pending response is dropped, and the clear restarts from address 0.
- Widths:
  - `clr_cnt` is IDX_W bits and wraps naturally at DEPTH-1.
  - `req_pos` is stored truncated to PTR_W; no overflow detection.

## Structure
- Shared package `lzrw_pkg` holds:
  - `IDX_W`, `PTR_W`, `KEY_W`=24.
  - The `tbl_entry_t` packed struct {valid, ptr}.
  - The `hctrl_state_t` enum.
- The hash unit and table RAM stay outside this block so they can be shared and swapped. No sub-module is needed inside; the FSM and clear counter are one module.

## Test plan
- Reset then idle: `busy` high for exactly 4096 cycles with `tbl_we`=1 at addresses 0…4095 → `req_ready`=1 on cycle 4096.
- First lookup of key 0x616263 at pos 5 → `rsp_valid` 3 cycles after the handshake, `rsp_hit`=0, `rsp_ptr`=0; entry {1,5} written at `hash_idx`.
- Same key again at pos 9 → `rsp_hit`=1, `rsp_ptr`=5; entry becomes {1,9}.
- `rsp_ready` held low 10 cycles → `rsp_valid` and `rsp_ptr` stable, `req_ready`=0, no RAM writes; IDLE the cycle after `rsp_ready`.
- `start` and `req_valid` both high in IDLE → `req_ready`=0, full clear runs; repeating key 0x616263 then gives `rsp_hit`=0.
- `reset` pulsed in the UPDATE cycle → next cycle is CLEAR at address 0, `rsp_valid` never asserts, 4096-cycle clear completes.
